// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl
//   Turns one-cycle key pulses into a multi-digit BCD value. In IDLE only
//   confirm does anything: it opens EDIT with a copy of the committed value.
//   In EDIT, up/down change the digit under the cursor (mod 10, no carry),
//   left/right move the cursor (with wrap), and confirm commits. An edit left
//   idle for TIMEOUT_CYC cycles is aborted.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | value_out stable, waiting for confirm to start an edit
//   EDIT  | edit_buf/cursor being modified, inactivity timer running
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   key_pulse     [0] up, [1] down, [2] left, [3] right, [4] confirm
//   value_out     committed BCD value, digit i at [4i+3:4i]
//   edit_buf      working BCD value during edit
//   cursor        index of digit being edited (0 = least significant)
//   editing       high while in EDIT
//   commit_pulse  one-cycle pulse when an edit is committed
//   abort_pulse   one-cycle pulse when an edit times out
module key_entry_ctrl #(
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 500_000_000,
  localparam int CW         = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            key_pulse,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [4*DIGITS-1:0]   edit_buf,
  output logic [CW-1:0]         cursor,
  output logic                  editing,
  output logic                  commit_pulse,
  output logic                  abort_pulse
);

  typedef enum logic {IDLE, EDIT} state_t;

  localparam logic [29:0]   TMR_LAST = 30'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CUR_MAX  = CW'(DIGITS - 1);

  state_t      state;
  logic [29:0] timer;
  logic [3:0]  cur_digit;
  logic [3:0]  digit_up;
  logic [3:0]  digit_dn;

  logic key_up, key_dn, key_left, key_right, key_confirm, key_any;

  assign key_up      = key_pulse[0];
  assign key_dn      = key_pulse[1];
  assign key_left    = key_pulse[2];
  assign key_right   = key_pulse[3];
  assign key_confirm = key_pulse[4];
  assign key_any     = |key_pulse;

  assign editing = (state == EDIT);

  // Digit under the cursor and its +1 / -1 neighbours, modulo 10.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cursor == CW'(i)) cur_digit = edit_buf[4*i +: 4];
    end
    digit_up = (cur_digit >= 4'd9) ? 4'd0 : 4'(cur_digit + 4'd1);
    digit_dn = (cur_digit == 4'd0) ? 4'd9 : 4'(cur_digit - 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      value_out    <= '0;
      edit_buf     <= '0;
      cursor       <= '0;
      timer        <= '0;
      commit_pulse <= 1'b0;
      abort_pulse  <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      abort_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (key_confirm) begin
            state    <= EDIT;
            edit_buf <= value_out;
            cursor   <= '0;
            timer    <= '0;
          end
        end
        EDIT: begin
          if (key_any) begin
            // Any accepted key restarts the inactivity window, even if the
            // timer is at its last count this cycle.
            timer <= '0;
            if (key_confirm) begin
              state        <= IDLE;
              value_out    <= edit_buf;
              commit_pulse <= 1'b1;
            end else if (key_up || key_dn) begin
              for (int i = 0; i < DIGITS; i++) begin
                if (cursor == CW'(i))
                  edit_buf[4*i +: 4] <= key_up ? digit_up : digit_dn;
              end
            end else if (key_left) begin
              cursor <= (cursor == CUR_MAX) ? '0 : CW'(cursor + 1'b1);
            end else if (key_right) begin
              cursor <= (cursor == '0) ? CUR_MAX : CW'(cursor - 1'b1);
            end
          end else if (timer == TMR_LAST) begin
            state       <= IDLE;
            abort_pulse <= 1'b1;
          end else begin
            timer <= timer + 30'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
module tb_key_entry_ctrl;

  localparam int DIGITS = 4;
  localparam int TOUT   = 20;

  localparam logic [4:0] K_UP = 5'b00001, K_DN = 5'b00010, K_LEFT = 5'b00100,
                         K_RIGHT = 5'b01000, K_CONF = 5'b10000, K_NONE = 5'b00000;

  logic        clk, rst_n;
  logic [4:0]  key_pulse;
  logic [15:0] value_out, edit_buf;
  logic [1:0]  cursor;
  logic        editing, commit_pulse, abort_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  key_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .value_out(value_out),
    .edit_buf(edit_buf), .cursor(cursor), .editing(editing),
    .commit_pulse(commit_pulse), .abort_pulse(abort_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: digits as integer arrays, the spec's rules in arithmetic.
  int m_val[DIGITS];
  int m_dig[DIGITS];
  int m_cur, m_tmr;
  bit m_edit, m_commit, m_abort;

  function automatic void model_reset();
    for (int i = 0; i < DIGITS; i++) begin m_val[i] = 0; m_dig[i] = 0; end
    m_cur = 0; m_tmr = 0; m_edit = 0; m_commit = 0; m_abort = 0;
  endfunction

  function automatic void model_step(input logic [4:0] k);
    m_commit = 0; m_abort = 0;
    if (!m_edit) begin
      if (k[4]) begin
        m_edit = 1; m_cur = 0; m_tmr = 0;
        for (int i = 0; i < DIGITS; i++) m_dig[i] = m_val[i];
      end
    end else if (k != 5'b0) begin
      m_tmr = 0;
      if (k[4]) begin
        m_edit = 0; m_commit = 1;
        for (int i = 0; i < DIGITS; i++) m_val[i] = m_dig[i];
      end
      else if (k[0]) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
      else if (k[1]) m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
      else if (k[2]) m_cur = (m_cur + 1) % DIGITS;
      else           m_cur = (m_cur + DIGITS - 1) % DIGITS;
    end else if (m_tmr == TOUT - 1) begin
      m_edit = 0; m_abort = 1;
    end else begin
      m_tmr++;
    end
  endfunction

  function automatic logic [15:0] m_value();
    int s = 0;
    for (int i = 0; i < DIGITS; i++) s += m_val[i] << (4 * i);
    return 16'(s);
  endfunction

  function automatic logic [15:0] m_buf();
    int s = 0;
    for (int i = 0; i < DIGITS; i++) s += m_dig[i] << (4 * i);
    return 16'(s);
  endfunction

  // Drive one key vector for one clock, then advance the model.
  task automatic step(input logic [4:0] k);
    @(negedge clk);
    key_pulse = k;
    @(posedge clk);
    model_step(k);
    #1;
    key_pulse = K_NONE;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_pulse = K_NONE;
    model_reset();
    #12;
    n_checks++;
    if ({value_out, edit_buf, cursor, editing, commit_pulse, abort_pulse} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_state: got value=%h buf=%h cur=%0d ed=%b c=%b a=%b, want all 0",
               value_out, edit_buf, cursor, editing, commit_pulse, abort_pulse);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    step(K_CONF);
    n_checks++;
    if (editing !== 1'b1 || edit_buf !== 16'h0000 || cursor !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_enter: got ed=%b buf=%h cur=%0d, want 1 0000 0", editing, edit_buf, cursor);
    end
    step(K_DN);
    n_checks++;
    if (edit_buf !== 16'h0009) begin n_fail++; $display("FAIL wrap_down: got %h want 0009", edit_buf); end
    step(K_UP);
    n_checks++;
    if (edit_buf !== 16'h0000) begin n_fail++; $display("FAIL wrap_up: got %h want 0000", edit_buf); end
    step(K_RIGHT);
    n_checks++;
    if (cursor !== 2'd3) begin n_fail++; $display("FAIL wrap_right: got %0d want 3", cursor); end
    step(K_LEFT);
    n_checks++;
    if (cursor !== 2'd0) begin n_fail++; $display("FAIL wrap_left: got %0d want 0", cursor); end
    step(K_CONF);
    n_checks++;
    if (value_out !== 16'h0000 || commit_pulse !== 1'b1) begin
      n_fail++; $display("FAIL wrap_commit: got value=%h c=%b want 0000 1", value_out, commit_pulse);
    end
  endtask

  task automatic test_basic();
    step(K_CONF);
    for (int i = 0; i < 3; i++) step(K_UP);
    step(K_LEFT);
    for (int i = 0; i < 12; i++) step(K_UP);
    n_checks++;
    if (edit_buf !== 16'h0023 || cursor !== 2'd1) begin
      n_fail++; $display("FAIL basic_buf: got buf=%h cur=%0d want 0023 1", edit_buf, cursor);
    end
    step(K_CONF);
    n_checks++;
    if (value_out !== 16'h0023 || commit_pulse !== 1'b1 || editing !== 1'b0 || abort_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_commit: got value=%h c=%b ed=%b a=%b want 0023 1 0 0",
               value_out, commit_pulse, editing, abort_pulse);
    end
    step(K_NONE);
    n_checks++;
    if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got c=%b want 0", commit_pulse); end
  endtask

  task automatic test_priority();
    logic [15:0] prev_buf;
    step(K_CONF);
    prev_buf = edit_buf;
    step(K_CONF | K_UP | K_LEFT);
    n_checks++;
    if (commit_pulse !== 1'b1 || value_out !== prev_buf || edit_buf !== prev_buf || editing !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_confirm: got c=%b value=%h buf=%h ed=%b want 1 %h %h 0",
               commit_pulse, value_out, edit_buf, editing, prev_buf, prev_buf);
    end
    step(K_CONF);
    step(K_UP | K_DN | K_LEFT);
    n_checks++;
    if (edit_buf !== m_buf() || edit_buf !== 16'h0024 || cursor !== 2'd0) begin
      n_fail++; $display("FAIL prio_up: got buf=%h cur=%0d want 0024 0", edit_buf, cursor);
    end
    step(K_CONF);
  endtask

  task automatic test_timeout();
    logic [15:0] prev_val;
    int got;
    prev_val = value_out;
    step(K_CONF);
    step(K_UP);
    got = -1;
    for (int n = 1; n <= 2 * TOUT; n++) begin
      step(K_NONE);
      if (abort_pulse === 1'b1) begin got = n; break; end
    end
    n_checks++;
    if (got != TOUT || value_out !== prev_val || editing !== 1'b0 || edit_buf !== m_buf()) begin
      n_fail++;
      $display("FAIL timeout_abort: got after=%0d value=%h ed=%b buf=%h want %0d %h 0 %h",
               got, value_out, editing, edit_buf, TOUT, prev_val, m_buf());
    end
    step(K_NONE);
    n_checks++;
    if (abort_pulse !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got a=%b want 0", abort_pulse); end

    step(K_CONF);
    step(K_UP);
    got = 0;
    for (int n = 1; n < TOUT - 1; n++) begin
      step(K_NONE);
      if (abort_pulse === 1'b1) got++;
    end
    step(K_UP);
    n_checks++;
    if (got != 0 || abort_pulse !== 1'b0 || editing !== 1'b1) begin
      n_fail++; $display("FAIL timeout_key_wins: got aborts=%0d a=%b ed=%b want 0 0 1", got, abort_pulse, editing);
    end
    got = -1;
    for (int n = 1; n <= 2 * TOUT; n++) begin
      step(K_NONE);
      if (abort_pulse === 1'b1) begin got = n; break; end
    end
    n_checks++;
    if (got != TOUT) begin n_fail++; $display("FAIL timeout_restart: got after=%0d want %0d", got, TOUT); end
  endtask

  task automatic test_idle_ignore();
    logic [15:0] v, b;
    logic [1:0]  c;
    v = value_out; b = edit_buf; c = cursor;
    for (int n = 0; n < 20; n++) begin
      step(5'($urandom_range(1, 15)));
      n_checks++;
      if (value_out !== v || edit_buf !== b || cursor !== c || editing !== 1'b0 ||
          commit_pulse !== 1'b0 || abort_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ignore: got value=%h buf=%h cur=%0d ed=%b c=%b a=%b want %h %h %0d 0 0 0",
                 value_out, edit_buf, cursor, editing, commit_pulse, abort_pulse, v, b, c);
      end
    end
  endtask

  task automatic test_async_reset();
    step(K_CONF);
    for (int d = 0; d < DIGITS; d++) begin
      while (m_dig[d] != 4 - d) step(K_UP);
      if (d < DIGITS - 1) step(K_LEFT);
    end
    step(K_CONF);
    n_checks++;
    if (value_out !== 16'h1234) begin n_fail++; $display("FAIL reset_setup: got %h want 1234", value_out); end
    step(K_CONF);
    step(K_LEFT);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({value_out, edit_buf, cursor, editing, commit_pulse, abort_pulse} !== 37'd0) begin
      n_fail++;
      $display("FAIL async_reset: got value=%h buf=%h cur=%0d ed=%b c=%b a=%b want all 0",
               value_out, edit_buf, cursor, editing, commit_pulse, abort_pulse);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(K_CONF);
    n_checks++;
    if (editing !== 1'b1 || edit_buf !== 16'h0000 || value_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_reenter: got ed=%b buf=%h value=%h want 1 0000 0000", editing, edit_buf, value_out);
    end
  endtask

  task automatic test_random();
    logic [4:0] k;
    int r;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        for (int j = 0; j < TOUT + 3; j++) step(K_NONE);
        k = K_NONE;
      end
      else if (r < 5)  k = K_NONE;
      else if (r < 7)  k = K_CONF;
      else if (r < 9)  k = 5'($urandom_range(1, 31));
      else             k = 5'(1 << $urandom_range(0, 3));
      step(k);
      n_checks++;
      if (value_out !== m_value() || edit_buf !== m_buf() || cursor !== 2'(m_cur) ||
          editing !== m_edit || commit_pulse !== m_commit || abort_pulse !== m_abort) begin
        n_fail++;
        $display("FAIL random[%0d] key=%b: got value=%h buf=%h cur=%0d ed=%b c=%b a=%b want %h %h %0d %b %b %b",
                 n, k, value_out, edit_buf, cursor, editing, commit_pulse, abort_pulse,
                 m_value(), m_buf(), m_cur, m_edit, m_commit, m_abort);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_basic();
    test_priority();
    test_timeout();
    test_idle_ignore();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
# key_entry_ctrl

Consumes the one-cycle key-press pulses produced by the debounced key filter stage and turns them into a multi-digit BCD value entered by the user. Two-state controller: up/down edit the digit under a cursor, left/right move the cursor, confirm enters or commits edit mode. An inactivity timer aborts an unfinished edit. Downstream logic (display driver, application FSM) reads the committed value and the edit buffer/cursor for display.

## Interface
- DIGITS, 4: number of BCD digits; legal range 2..8.
- TIMEOUT_CYC, 500_000_000: idle cycles in EDIT before abort (10 s at 50 MHz); legal range 2..2^30-1.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- key_pulse  in  5  one-clk-wide press pulses from the key filter: [0] up, [1] down, [2] left, [3] right, [4] confirm.
- value_out  out  4*DIGITS  committed BCD value; digit i in bits [4i+3:4i].
- edit_buf  out  4*DIGITS  working BCD value during edit.
- cursor  out  clog2(DIGITS)  index of digit being edited (0 = least significant).
- editing  out  1  high while in EDIT.
- commit_pulse  out  1  one-cycle pulse when an edit is committed.
- abort_pulse  out  1  one-cycle pulse when an edit times out.

## Operation
- States: IDLE, EDIT. Reset → IDLE.
- Per-cycle key arbitration, only one key acts per cycle. Priority: confirm > up > down > left > right. Lower-priority simultaneous pulses are dropped.
- IDLE:
  - confirm → EDIT; edit_buf <= value_out; cursor <= 0; timer <= 0.
  - All other keys are ignored.
- EDIT, confirm → IDLE; value_out <= edit_buf; commit_pulse = 1 for one cycle.
- EDIT, up: digit[cursor] +1 modulo 10 (9 → 0). Other digits unchanged, no carry.
- EDIT, down: digit[cursor] −1 modulo 10 (0 → 9), no borrow.
- EDIT, left: cursor +1, wraps DIGITS−1 → 0.
- EDIT, right: cursor −1, wraps 0 → DIGITS−1.
- Inactivity timer, EDIT only:
  - An accepted key clears it to 0; otherwise it increments every cycle.
  - When timer == TIMEOUT_CYC−1 and no key is accepted that cycle → IDLE; abort_pulse = 1; value_out unchanged; edit_buf keeps its last contents.
- Key vs. timeout in the same cycle: the key wins and the timer clears.
- Width: timer is 30 bits. Digits always remain valid BCD because edit_buf is only loaded from value_out, which resets to 0.

## Timing
- Reset values: value_out = 0, edit_buf = 0, cursor = 0, editing = 0, commit_pulse = 0, abort_pulse = 0, timer = 0, state = IDLE.
- Reset is asynchronous. Asserting it mid-edit returns every register to its reset value immediately, with no commit.
- key_pulse is sampled on the rising edge of clk. Its effect appears on the outputs one cycle later (registered, single-cycle latency).
- editing rises the cycle after the entering confirm and falls in the same cycle that commit_pulse or abort_pulse is high.
- commit_pulse and abort_pulse are registered, exactly one clk wide, and mutually exclusive.
- value_out updates in the same cycle commit_pulse is high.
- A key held high for several cycles (not expected from the filter) acts once per cycle. No edge detection is done here.
- Abort fires TIMEOUT_CYC cycles after the last accepted key, or after entry into EDIT.

## Test plan
- Reset, then a confirm pulse → editing = 1 next cycle, edit_buf = 0x0000, cursor = 0. Up ×3, left, up ×12, confirm → value_out = 0x0023, commit_pulse high for 1 cycle, editing = 0.
- Wrap: in EDIT at digit 0 = 0, down → 9. Up → 0. Right at cursor 0 → cursor 3. Left at cursor 3 → cursor 0.
- Priority: in EDIT, drive confirm|up|left in the same cycle → commit only, edit_buf digit unchanged. Drive up|down|left → +1 only, cursor unchanged.
- Timeout with TIMEOUT_CYC = 20: enter EDIT, up once, then idle → abort_pulse exactly 20 cycles after the up, value_out still at its previous value. A second run with a key on cycle 19 → no abort, and the timer restarts.
- IDLE ignores up/down/left/right: value_out, edit_buf and cursor stay constant, with no pulses.
- Mid-edit rst_n low for 1 cycle after value_out = 0x1234 → all outputs 0, state IDLE. The next confirm loads edit_buf = 0x0000.
